// File: rtl/sprite_line_fetch.sv
// Walks one sprite line pixel by pixel and issues one sprite-memory address per pixel tick.
// Pulses count_finished with the last address, then holds off until sprite_on drops.
module sprite_line_fetch #(
  parameter int size_address = 14,
  parameter int len_bits     = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sprite_on,
  input  logic [31:0]             sprite_datas,
  input  logic                    pixel_tick,
  output logic [size_address-1:0] memory_address,
  output logic                    addr_valid,
  output logic                    count_finished,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

  state_t                  state;
  logic [size_address-1:0] base;
  logic [len_bits-1:0]     last;
  logic [len_bits-1:0]     count;

  // Bits above the length field carry nothing for this stage.
  logic unused_datas;
  assign unused_datas = ^sprite_datas[31:size_address+len_bits];

  // Dropping sprite_on in LOAD/DRAW aborts the line silently; DONE waits for it to drop
  // so the print FSM leaving SPRITE cannot retrigger the same line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      base           <= '0;
      last           <= '0;
      count          <= '0;
      memory_address <= '0;
      addr_valid     <= 1'b0;
      count_finished <= 1'b0;
      busy           <= 1'b0;
    end else begin
      addr_valid     <= 1'b0;
      count_finished <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          if (sprite_on) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          count <= '0;
          if (!sprite_on) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            base  <= sprite_datas[size_address-1:0];
            last  <= sprite_datas[size_address+len_bits-1:size_address];
            state <= DRAW;
          end
        end
        DRAW: begin
          if (!sprite_on) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= '0;
          end else if (pixel_tick) begin
            memory_address <= base + size_address'(count);
            addr_valid     <= 1'b1;
            if (count == last) begin
              count_finished <= 1'b1;
              state          <= DONE;
            end else begin
              count <= count + len_bits'(1);
            end
          end
        end
        DONE: begin
          if (!sprite_on) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_line_fetch.sv
// Randomised scoreboard bench for sprite_line_fetch: stimulus predicts pixel addresses from
// base/length arithmetic, a negedge monitor pops them whenever addr_valid is seen.
module tb_sprite_line_fetch;

  localparam int AW = 14;
  localparam int LW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          sprite_on;
  logic [31:0]   sprite_datas;
  logic          pixel_tick;
  logic [AW-1:0] memory_address;
  logic          addr_valid;
  logic          count_finished;
  logic          busy;

  typedef struct {
    int addr;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  sprite_line_fetch #(.size_address(AW), .len_bits(LW)) dut (
    .clk            (clk),
    .reset          (reset),
    .sprite_on      (sprite_on),
    .sprite_datas   (sprite_datas),
    .pixel_tick     (pixel_tick),
    .memory_address (memory_address),
    .addr_valid     (addr_valid),
    .count_finished (count_finished),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Monitor: every address the DUT presents must match the oldest predicted pixel.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check_output("finish_without_valid", {31'b0, count_finished & ~addr_valid}, 32'd0);
      if (addr_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_addr actual=%0h required=none", memory_address);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("pixel_addr", {18'b0, memory_address}, e.addr);
          check_output("pixel_finished", {31'b0, count_finished}, {31'b0, e.last});
        end
      end
    end
  end

  task automatic apply_cycle(input bit on, input bit tick);
    sprite_on  = on;
    pixel_tick = tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check_output({name, "_addr"}, {18'b0, memory_address}, 32'd0);
    check_output({name, "_valid"}, {31'b0, addr_valid}, 32'd0);
    check_output({name, "_finished"}, {31'b0, count_finished}, 32'd0);
    check_output({name, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  // One line: abort_after<0 means run to completion, else drop sprite_on after that many ticks.
  task automatic run_line(input logic [AW-1:0] base, input logic [LW-1:0] lastf,
                          input int abort_after, input int hold, input int tick_pct);
    int issued = 0;
    int cyc    = 0;
    bit t;
    sprite_datas = $urandom();
    sprite_datas[AW-1:0] = base;
    sprite_datas[AW+LW-1:AW] = lastf;
    apply_cycle(1'b1, 1'($urandom_range(0, 1)));
    check_output("busy_load", {31'b0, busy}, 32'd1);
    apply_cycle(1'b1, 1'($urandom_range(0, 1)));
    sprite_datas = $urandom();
    while (issued <= int'(lastf)) begin
      if (abort_after >= 0 && issued == abort_after) begin
        apply_cycle(1'b0, 1'($urandom_range(0, 1)));
        check_output("busy_abort", {31'b0, busy}, 32'd0);
        return;
      end
      t = ($urandom_range(0, 99) < tick_pct) || (cyc > 200);
      if (t) begin
        exp_q.push_back('{addr: (int'(base) + issued) % (1 << AW), last: (issued == int'(lastf))});
        issued++;
      end
      apply_cycle(1'b1, t);
      cyc++;
    end
    repeat (hold) begin
      sprite_datas = $urandom();
      apply_cycle(1'b1, 1'($urandom_range(0, 1)));
    end
    check_output("busy_done", {31'b0, busy}, 32'd1);
    apply_cycle(1'b0, 1'($urandom_range(0, 1)));
    check_output("busy_idle", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset        = 1'b0;
    sprite_on    = 1'b0;
    pixel_tick   = 1'b0;
    sprite_datas = '0;

    // Reset held with random activity on the inputs.
    for (int i = 0; i < 4; i++) begin
      sprite_on    = 1'($urandom_range(0, 1));
      pixel_tick   = 1'($urandom_range(0, 1));
      sprite_datas = $urandom();
      @(posedge clk);
      #1;
      check_all_zero("reset_hold");
    end
    sprite_on  = 1'b0;
    pixel_tick = 1'b0;
    reset      = 1'b1;
    apply_cycle(1'b0, 1'b0);

    run_line(14'h0100, 6'd19, -1, 0, 100);
    run_line(14'h3FFE, 6'd3, -1, 0, 60);
    run_line(14'h0042, 6'd0, -1, 0, 50);
    run_line(14'h0200, 6'd19, 5, 0, 100);
    run_line(14'h1234, 6'd4, -1, 0, 70);
    run_line(14'h0300, 6'd2, -1, 3, 80);

    // Reset in the middle of a line: immediate zeros, nothing emitted on release.
    sprite_datas = {12'h0, 6'd30, 14'h0500};
    apply_cycle(1'b1, 1'b0);
    apply_cycle(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{addr: 32'h500 + i, last: 1'b0});
      apply_cycle(1'b1, 1'b1);
    end
    apply_cycle(1'b1, 1'b0);
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid");
    apply_cycle(1'b1, 1'b1);
    apply_cycle(1'b0, 1'b1);
    reset = 1'b1;
    repeat (3) apply_cycle(1'b0, 1'b1);
    check_all_zero("reset_release");

    for (int n = 0; n < 25; n++) begin
      logic [AW-1:0] b;
      logic [LW-1:0] l;
      int ab;
      b  = AW'($urandom());
      l  = LW'($urandom());
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, int'(l)) : -1;
      run_line(b, l, ab, $urandom_range(0, 4), $urandom_range(20, 100));
    end

    repeat (5) apply_cycle(1'b0, 1'b0);
    check_output("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
